an_fix_scheduler_n13: RTL and testbench

Sequential front-end for the n=13 AN-code decoder array. It accepts one 4x4 block of 6-bit codewords per handshake, reduces all 16 cells in parallel with `barrett_n13`, and then time-shares a single `an_decoder_n13` across every erroneous cell, correcting one cell per clock. It sits between the block source and the message consumer, and replaces single-correction combinational 4x4 wrappers wherever more than one error per block must be corrected.

---
 rtl/an_fix_scheduler_n13.sv | 193 +++++++++++++++++++
 tb/tb_an_fix_scheduler_n13.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/an_fix_scheduler_n13.sv
// an_fix_scheduler_n13
// Sequential front-end for the n=13 AN-code decoder array. One 4x4 block of
// 6-bit codewords is accepted per handshake. All 16 cells are reduced in
// parallel by barrett_n13, and then one shared an_decoder_n13 corrects one
// erroneous cell per clock, lowest cell index first, up to MAX_FIX cells.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : block input handshake (in_ready high only in IDLE)
//   in_codewords [95:0] : cell i at [6i+5:6i], i = 4*row + col
//   out_valid/out_ready : result handshake (out_valid high only in OUT)
//   out_data     [47:0] : decoded message for cell i at [3i+2:3i]
//   out_err_mask [15:0] : cells whose barrett error flag was set
//   out_err_rows/cols   : row / column OR of the error flags
//   out_fix_count [4:0] : number of corrections applied
//   out_overflow        : erroneous cells were left uncorrected (MAX_FIX hit)

// Reduces a 6-bit codeword modulo 13: q = cw / 13, r = cw % 13.
// The quotient is estimated as (cw * 19) >> 8, which is never too high and
// at most one too low over 0..63, so a single conditional subtract finishes it.
module barrett_n13 (
  input  logic [5:0] cw,
  output logic [2:0] q,
  output logic [3:0] r,
  output logic       error
);
  logic [10:0] prod;
  logic [2:0]  q_est;
  logic [6:0]  r_full;

  assign prod   = {5'd0, cw} * 11'd19;
  assign q_est  = 3'(prod >> 8);
  assign r_full = {1'b0, cw} - ({4'd0, q_est} * 7'd13);

  always_comb begin
    if (r_full >= 7'd13) begin
      q = q_est + 3'd1;
      r = 4'(r_full - 7'd13);
    end else begin
      q = q_est;
      r = 4'(r_full);
    end
  end

  assign error = (r != 4'd0);
endmodule

// Rounds to the nearest multiple of 13: residues 7..12 lie closer to the
// next codeword, so the message is bumped by one.
module an_decoder_n13 (
  input  logic [2:0] q,
  input  logic [3:0] r,
  output logic [2:0] msg
);
  assign msg = (r >= 4'd7) ? (q + 3'd1) : q;
endmodule

module an_fix_scheduler_n13 #(
  parameter int MAX_FIX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] in_codewords,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic [15:0] out_err_mask,
  output logic [3:0]  out_err_rows,
  output logic [3:0]  out_err_cols,
  output logic [4:0]  out_fix_count,
  output logic        out_overflow
);
  typedef enum logic [1:0] {IDLE, EVAL, FIX, OUT} state_t;

  localparam logic [4:0] MAX_FIX_W = 5'(MAX_FIX);

  state_t      state_reg, state_next;
  logic [95:0] cw_reg;
  logic [2:0]  q_reg [16];
  logic [3:0]  r_reg [16];
  logic [15:0] err_reg;
  logic [15:0] cand_reg;
  logic [4:0]  fix_cnt_reg;
  logic        overflow_reg;

  logic [2:0]  bq [16];
  logic [3:0]  br [16];
  logic [15:0] berr;
  logic [3:0]  eval_rows, eval_cols;
  logic [15:0] cand_w;

  logic [3:0]  idx;
  logic [15:0] cand_cleared;
  logic        fix_last;
  logic [2:0]  dec_msg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cell
      barrett_n13 u_barrett (
        .cw    (cw_reg[6*gi +: 6]),
        .q     (bq[gi]),
        .r     (br[gi]),
        .error (berr[gi])
      );
      assign cand_w[gi]        = eval_rows[gi/4] & eval_cols[gi%4] & berr[gi];
      assign out_data[3*gi +: 3] = q_reg[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_line
      assign eval_rows[gi]    = |berr[4*gi +: 4];
      assign eval_cols[gi]    = berr[gi] | berr[gi+4] | berr[gi+8] | berr[gi+12];
      assign out_err_rows[gi] = |err_reg[4*gi +: 4];
      assign out_err_cols[gi] = err_reg[gi] | err_reg[gi+4] | err_reg[gi+8] | err_reg[gi+12];
    end
  endgenerate

  // Lowest pending candidate wins the shared decoder this cycle.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (cand_reg[i]) idx = 4'(i);
    end
  end

  an_decoder_n13 u_decoder (
    .q   (q_reg[idx]),
    .r   (r_reg[idx]),
    .msg (dec_msg)
  );

  assign cand_cleared = cand_reg & ~(16'd1 << idx);
  assign fix_last     = (cand_cleared == 16'd0) || ((fix_cnt_reg + 5'd1) == MAX_FIX_W);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)             state_next = EVAL;
      EVAL: state_next = (cand_w == 16'd0) ? OUT : FIX;
      FIX:  if (fix_last)             state_next = OUT;
      OUT:  if (out_ready)            state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_reg       <= '0;
      err_reg      <= '0;
      cand_reg     <= '0;
      fix_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        q_reg[i] <= '0;
        r_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: if (in_valid) cw_reg <= in_codewords;
        EVAL: begin
          for (int i = 0; i < 16; i++) begin
            q_reg[i] <= bq[i];
            r_reg[i] <= br[i];
          end
          err_reg      <= berr;
          cand_reg     <= cand_w;
          fix_cnt_reg  <= '0;
          overflow_reg <= 1'b0;
        end
        FIX: begin
          q_reg[idx]  <= dec_msg;
          cand_reg    <= cand_cleared;
          fix_cnt_reg <= fix_cnt_reg + 5'd1;
          // Leaving with candidates still pending means MAX_FIX cut us short.
          if (fix_last) overflow_reg <= (cand_cleared != 16'd0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_reg == IDLE);
  assign out_valid     = (state_reg == OUT);
  assign out_err_mask  = err_reg;
  assign out_fix_count = fix_cnt_reg;
  assign out_overflow  = overflow_reg;
endmodule

// File: tb/tb_an_fix_scheduler_n13.sv
module tb_an_fix_scheduler_n13;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          sel = 0;

  logic        iv0 = 1'b0, iv1 = 1'b0, or0 = 1'b0, or1 = 1'b0;
  logic [95:0] icw0 = '0, icw1 = '0;
  logic        ir0, ir1, ov0, ov1, ovf0, ovf1;
  logic [47:0] od0, od1;
  logic [15:0] om0, om1;
  logic [3:0]  orw0, orw1, ocl0, ocl1;
  logic [4:0]  ofc0, ofc1;

  always #5 clk = ~clk;

  an_fix_scheduler_n13 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_codewords(icw0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_err_mask(om0),
    .out_err_rows(orw0), .out_err_cols(ocl0), .out_fix_count(ofc0), .out_overflow(ovf0)
  );

  an_fix_scheduler_n13 #(.MAX_FIX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_codewords(icw1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_err_mask(om1),
    .out_err_rows(orw1), .out_err_cols(ocl1), .out_fix_count(ofc1), .out_overflow(ovf1)
  );

  wire        m_ir  = sel ? ir1  : ir0;
  wire        m_ov  = sel ? ov1  : ov0;
  wire [47:0] m_od  = sel ? od1  : od0;
  wire [15:0] m_om  = sel ? om1  : om0;
  wire [3:0]  m_orw = sel ? orw1 : orw0;
  wire [3:0]  m_ocl = sel ? ocl1 : ocl0;
  wire [4:0]  m_ofc = sel ? ofc1 : ofc0;
  wire        m_ovf = sel ? ovf1 : ovf0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each cell is the nearest multiple of 13 (rounded), applied to
  // erroneous cells in ascending order until the correction budget runs out.
  task automatic model(input logic [95:0] cw, input int max_fix,
                       output logic [47:0] data, output logic [15:0] mask,
                       output logic [3:0] rows, output logic [3:0] cols,
                       output int fixes, output logic ovf);
    int errs = 0;
    data = '0; mask = '0; rows = '0; cols = '0; fixes = 0;
    for (int i = 0; i < 16; i++) begin
      int v = int'(cw[6*i +: 6]);
      int d = v / 13;
      if (v % 13 != 0) begin
        errs++;
        mask[i] = 1'b1;
        rows[i/4] = 1'b1;
        cols[i%4] = 1'b1;
        if (fixes < max_fix) begin
          d = (v + 6) / 13;
          fixes++;
        end
      end
      data[3*i +: 3] = 3'(d);
    end
    ovf = (errs > max_fix);
  endtask

  function automatic logic [95:0] fill(input int v);
    logic [95:0] r;
    for (int i = 0; i < 16; i++) r[6*i +: 6] = 6'(v);
    return r;
  endfunction

  task automatic drive_in(input logic v, input logic [95:0] cw);
    if (sel == 0) begin iv0 = v; icw0 = cw; end
    else          begin iv1 = v; icw1 = cw; end
  endtask

  task automatic drive_ready(input logic v);
    if (sel == 0) or0 = v; else or1 = v;
  endtask

  task automatic send(input int s, input logic [95:0] cw, input int hold, input string name);
    logic [47:0] e_data, s_data;
    logic [15:0] e_mask;
    logic [3:0]  e_rows, e_cols;
    int          e_fix, lat;
    logic        e_ovf;
    sel = s;
    model(cw, (s == 0) ? 16 : 1, e_data, e_mask, e_rows, e_cols, e_fix, e_ovf);
    @(negedge clk);
    chk({name, ".in_ready_idle"}, m_ir, 1'b1);
    drive_in(1'b1, cw);
    drive_ready(hold == 0);
    @(posedge clk);
    #1;
    // With backpressure, keep offering a junk block that must be ignored.
    if (hold > 0) drive_in(1'b1, fill(1)); else drive_in(1'b0, '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_ov && lat < 40);
    chk({name, ".out_valid"}, m_ov, 1'b1);
    chk({name, ".latency"}, lat, 2 + e_fix);
    chk({name, ".data"}, m_od, e_data);
    chk({name, ".mask"}, m_om, e_mask);
    chk({name, ".rows"}, m_orw, e_rows);
    chk({name, ".cols"}, m_ocl, e_cols);
    chk({name, ".fix_count"}, m_ofc, e_fix);
    chk({name, ".overflow"}, m_ovf, e_ovf);
    chk({name, ".in_ready_busy"}, m_ir, 1'b0);
    s_data = m_od;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, ".hold_valid"}, m_ov, 1'b1);
      chk({name, ".hold_ready"}, m_ir, 1'b0);
      chk({name, ".hold_data"}, m_od, s_data);
      chk({name, ".hold_fix"}, m_ofc, e_fix);
    end
    if (hold > 0) begin
      drive_in(1'b0, '0);
      drive_ready(1'b1);
    end
    @(negedge clk);
    chk({name, ".post_valid"}, m_ov, 1'b0);
    chk({name, ".post_ready"}, m_ir, 1'b1);
    drive_ready(1'b0);
    $display("txn %s dut=%0d fix=%0d ovf=%0d lat=%0d", name, s, e_fix, e_ovf, lat);
  endtask

  function automatic logic [95:0] rand_block();
    logic [95:0] r;
    int dens = $urandom_range(0, 100);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 99) < dens) r[6*i +: 6] = 6'($urandom_range(0, 63));
      else                              r[6*i +: 6] = 6'(13 * $urandom_range(0, 4));
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] cw;
    #1;
    chk("reset.in_ready", ir0, 1'b1);
    chk("reset.out_valid", ov0, 1'b0);
    chk("reset.data", od0, 48'd0);
    chk("reset.mask", om0, 16'd0);
    chk("reset.rows_cols", {orw0, ocl0}, 8'd0);
    chk("reset.fix_ovf", {ofc0, ovf0}, 6'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(0, fill(26), 0, "all26");
    cw = fill(26); cw[30 +: 6] = 6'd25;
    send(0, cw, 0, "cell5");
    cw = fill(26); cw[0 +: 6] = 6'd25; cw[90 +: 6] = 6'd25;
    send(0, cw, 0, "cells0_15");
    send(1, cw, 0, "maxfix1");
    cw = fill(39); cw[12 +: 6] = 6'd41;
    send(0, cw, 5, "backpressure");

    // Asynchronous reset in the second FIX cycle of a 4-error block.
    sel = 0;
    cw = fill(13);
    cw[0 +: 6] = 6'd14; cw[24 +: 6] = 6'd12; cw[54 +: 6] = 6'd20; cw[90 +: 6] = 6'd50;
    @(negedge clk);
    drive_in(1'b1, cw);
    drive_ready(1'b1);
    @(posedge clk);
    #1 drive_in(1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstfix.in_ready", ir0, 1'b1);
    chk("rstfix.out_valid", ov0, 1'b0);
    chk("rstfix.data", od0, 48'd0);
    chk("rstfix.mask", om0, 16'd0);
    chk("rstfix.fix_ovf", {ofc0, ovf0}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_ready(1'b0);
    $display("txn rstfix dut=0 reset asserted mid-fix");
    send(0, cw, 0, "after_rst");

    for (int t = 0; t < 30; t++) send(0, rand_block(), (t % 7 == 3) ? 2 : 0, "rand16");
    for (int t = 0; t < 10; t++) send(1, rand_block(), 0, "rand1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
